// File: rtl/alu_writeback_pkg.sv
// rtl/alu_writeback_pkg.sv - shared opcodes, lane geometry and FSM state type for ALU writeback
package alu_pkg;
   localparam int LANE_W    = 16;
   localparam int NUM_LANES = 17;

   localparam logic [5:0] OP_MOV   = 6'd0;
   localparam logic [5:0] OP_LDI   = 6'd1;
   localparam logic [5:0] OP_LOAD  = 6'd2;
   localparam logic [5:0] OP_STORE = 6'd3;
   localparam logic [5:0] OP_ADD   = 6'd4;
   localparam logic [5:0] OP_SUB   = 6'd5;
   localparam logic [5:0] OP_AND   = 6'd6;
   localparam logic [5:0] OP_MUL   = 6'd7;
   localparam logic [5:0] OP_DIV   = 6'd8;
   localparam logic [5:0] OP_OR    = 6'd9;
   localparam logic [5:0] OP_XOR   = 6'd10;
   localparam logic [5:0] OP_NOT   = 6'd11;
   localparam logic [5:0] OP_CMP   = 6'd12;
   localparam logic [5:0] OP_LSH   = 6'd13;
   localparam logic [5:0] OP_RSH   = 6'd14;
   localparam logic [5:0] OP_ALSH  = 6'd15;
   localparam logic [5:0] OP_LRSH  = 6'd16;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_DIV = 2'd1,
      S_WR_LO    = 2'd2,
      S_WR_HI    = 2'd3
   } wb_state_t;

   function automatic logic is_illegal_op(input logic [5:0] op);
      return op > OP_LRSH;
   endfunction
endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - upstream instruction and register-file write bundle for alu_writeback
interface alu_writeback_if import alu_pkg::*;;
   logic                          in_valid;
   logic                          in_ready;
   logic [5:0]                    opcode;
   logic [5:0]                    rdst1;
   logic [5:0]                    rdst2;
   logic [NUM_LANES*LANE_W-1:0]   alu_res;
   logic [LANE_W-1:0]             mul_hi;
   logic                          div_done;
   logic [LANE_W-1:0]             div_q;
   logic                          wr_en;
   logic [5:0]                    wr_addr;
   logic [LANE_W-1:0]             wr_data;
   logic                          retire;
   logic                          illegal;

   modport master (
      output in_valid, opcode, rdst1, rdst2, alu_res, mul_hi, div_done, div_q,
      input  in_ready, wr_en, wr_addr, wr_data, retire, illegal
   );

   modport slave (
      input  in_valid, opcode, rdst1, rdst2, alu_res, mul_hi, div_done, div_q,
      output in_ready, wr_en, wr_addr, wr_data, retire, illegal
   );
endinterface

// File: rtl/alu_writeback_lane_sel.sv
// rtl/alu_writeback_lane_sel.sv - picks the 16-bit result lane matching the opcode (zero when out of range)
module wb_lane_sel import alu_pkg::*; (
   input  logic [5:0]                  i_opcode,
   input  logic [NUM_LANES*LANE_W-1:0] i_alu_res,
   output logic [LANE_W-1:0]           o_lane
);
   always_comb begin
      o_lane = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (i_opcode == 6'(k)) o_lane = i_alu_res[k*LANE_W +: LANE_W];
      end
   end
endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - writeback FSM: accepts one ALU result, waits on the divider if needed, writes the register file
module alu_writeback import alu_pkg::*; (
   input  logic          clk,
   input  logic          rst_n,
   alu_writeback_if.slave bus
);
   wb_state_t          r_state;
   wb_state_t          w_next;
   logic [5:0]         r_opcode;
   logic [5:0]         r_rdst1;
   logic [5:0]         r_rdst2;
   logic [LANE_W-1:0]  r_mul_hi;
   logic               r_wr_en;
   logic [5:0]         r_wr_addr;
   logic [LANE_W-1:0]  r_wr_data;
   logic               r_retire;
   logic               r_illegal;

   logic [LANE_W-1:0]  w_lane;
   logic               w_accept;
   logic [5:0]         w_op_eff;
   logic               w_wr_en_nxt;
   logic [5:0]         w_wr_addr_nxt;
   logic [LANE_W-1:0]  w_wr_data_nxt;
   logic               w_retire_nxt;
   logic               w_illegal_nxt;

   wb_lane_sel u_lane_sel (
      .i_opcode  (bus.opcode),
      .i_alu_res (bus.alu_res),
      .o_lane    (w_lane)
   );

   assign w_accept = bus.in_valid && (r_state == S_IDLE);
   assign w_op_eff = (r_state == S_IDLE) ? bus.opcode : r_opcode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (bus.opcode == OP_DIV)                                     w_next = S_WAIT_DIV;
               else if (bus.opcode == OP_STORE || is_illegal_op(bus.opcode)) w_next = S_IDLE;
               else                                                          w_next = S_WR_LO;
            end
         end
         S_WAIT_DIV: if (bus.div_done) w_next = S_WR_LO;
         S_WR_LO:    w_next = (r_opcode == OP_MUL) ? S_WR_HI : S_IDLE;
         S_WR_HI:    w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so they appear registered in that state.
   always_comb begin
      w_wr_en_nxt   = (w_next == S_WR_LO) || (w_next == S_WR_HI);
      w_wr_addr_nxt = '0;
      w_wr_data_nxt = '0;
      if (w_next == S_WR_LO) begin
         w_wr_addr_nxt = (r_state == S_IDLE) ? bus.rdst1 : r_rdst1;
         w_wr_data_nxt = (r_state == S_IDLE) ? w_lane : bus.div_q;
      end else if (w_next == S_WR_HI) begin
         w_wr_addr_nxt = r_rdst2;
         w_wr_data_nxt = r_mul_hi;
      end
      w_retire_nxt  = (w_next == S_WR_HI)
                   || ((w_next == S_WR_LO) && (w_op_eff != OP_MUL))
                   || (w_accept && (bus.opcode == OP_STORE));
      w_illegal_nxt = w_accept && is_illegal_op(bus.opcode);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode  <= '0;
         r_rdst1   <= '0;
         r_rdst2   <= '0;
         r_mul_hi  <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_retire  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_retire  <= w_retire_nxt;
         r_illegal <= w_illegal_nxt;
         if (w_accept) begin
            r_opcode <= bus.opcode;
            r_rdst1  <= bus.rdst1;
            r_rdst2  <= bus.rdst2;
            r_mul_hi <= bus.mul_hi;
         end
      end
   end

   assign bus.in_ready = (r_state == S_IDLE);
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign bus.retire   = r_retire;
   assign bus.illegal  = r_illegal;
endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed and randomized self-checking bench for alu_writeback
module tb_alu_writeback;
   import alu_pkg::*;

   typedef struct packed {
      logic        wr_en;
      logic [5:0]  addr;
      logic [15:0] data;
      logic        retire;
      logic        illegal;
      logic        in_ready;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_writeback_if bus();

   alu_writeback dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_cycle(input string tag, input exp_t e);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(e.in_ready));
      chk({tag, " wr_en"},    32'(bus.wr_en),    32'(e.wr_en));
      chk({tag, " retire"},   32'(bus.retire),   32'(e.retire));
      chk({tag, " illegal"},  32'(bus.illegal),  32'(e.illegal));
      if (e.wr_en) begin
         chk({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(e.addr));
         chk({tag, " wr_data"}, 32'(bus.wr_data), 32'(e.data));
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, " wr_en"},    32'(bus.wr_en),    32'd0);
      chk({tag, " retire"},   32'(bus.retire),   32'd0);
      chk({tag, " illegal"},  32'(bus.illegal),  32'd0);
   endtask

   task automatic scramble_inputs();
      for (int k = 0; k < NUM_LANES; k++) bus.alu_res[k*LANE_W +: LANE_W] = 16'($urandom);
      bus.mul_hi = 16'($urandom);
      bus.opcode = 6'($urandom);
      bus.rdst1  = 6'($urandom);
      bus.rdst2  = 6'($urandom);
   endtask

   // Reference: a whole instruction expands into the per-cycle outputs seen after the accept edge.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] r1,
                            input logic [5:0] r2, input logic [15:0] lane_v,
                            input logic [15:0] mh, input logic [15:0] dq, input int d);
      exp_t          q[$];
      logic [271:0]  res;
      if (op > 6'd16) begin
         q.push_back('{wr_en:1'b0, addr:6'd0, data:16'd0, retire:1'b0, illegal:1'b1, in_ready:1'b1});
      end else if (op == 6'd3) begin
         q.push_back('{wr_en:1'b0, addr:6'd0, data:16'd0, retire:1'b1, illegal:1'b0, in_ready:1'b1});
      end else if (op == 6'd8) begin
         for (int i = 0; i < d; i++)
            q.push_back('{wr_en:1'b0, addr:6'd0, data:16'd0, retire:1'b0, illegal:1'b0, in_ready:1'b0});
         q.push_back('{wr_en:1'b1, addr:r1, data:dq, retire:1'b1, illegal:1'b0, in_ready:1'b0});
      end else if (op == 6'd7) begin
         q.push_back('{wr_en:1'b1, addr:r1, data:lane_v, retire:1'b0, illegal:1'b0, in_ready:1'b0});
         q.push_back('{wr_en:1'b1, addr:r2, data:mh, retire:1'b1, illegal:1'b0, in_ready:1'b0});
      end else begin
         q.push_back('{wr_en:1'b1, addr:r1, data:lane_v, retire:1'b1, illegal:1'b0, in_ready:1'b0});
      end

      for (int k = 0; k < 17; k++) res[k*16 +: 16] = 16'($urandom);
      if (op <= 6'd16) res[int'(op)*16 +: 16] = lane_v;

      chk({tag, " ready_before_accept"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.rdst1    = r1;
      bus.rdst2    = r2;
      bus.alu_res  = res;
      bus.mul_hi   = mh;
      bus.div_done = 1'($urandom);
      bus.div_q    = 16'($urandom);
      @(negedge clk);
      for (int c = 1; c <= q.size(); c++) begin
         check_cycle($sformatf("%s c%0d", tag, c), q[c-1]);
         bus.in_valid = 1'b0;
         scramble_inputs();
         if (op == 6'd8) begin
            bus.div_done = (c == d);
            bus.div_q    = (c == d) ? dq : 16'($urandom);
         end else begin
            bus.div_done = 1'($urandom);
            bus.div_q    = 16'($urandom);
         end
         @(negedge clk);
      end
      check_quiet({tag, " after"});
      bus.div_done = 1'b0;
   endtask

   initial begin
      logic [5:0]  op;
      int          sel;
      bus.in_valid = 1'b0;
      bus.opcode   = '0;
      bus.rdst1    = '0;
      bus.rdst2    = '0;
      bus.alu_res  = '0;
      bus.mul_hi   = '0;
      bus.div_done = 1'b0;
      bus.div_q    = '0;

      #1;
      check_quiet("reset");
      chk("reset wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("reset wr_data", 32'(bus.wr_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_instr("add",      6'd4,  6'd5,  6'd0,  16'h1234, 16'h0000, 16'h0000, 0);
      run_instr("mul",      6'd7,  6'd2,  6'd3,  16'hBEEF, 16'h00CA, 16'h0000, 0);
      run_instr("div",      6'd8,  6'd9,  6'd0,  16'h5555, 16'h0000, 16'h0007, 10);
      run_instr("store",    6'd3,  6'd1,  6'd2,  16'hAAAA, 16'h0000, 16'h0000, 0);
      run_instr("illegal",  6'h20, 6'd1,  6'd2,  16'hAAAA, 16'h0000, 16'h0000, 0);
      run_instr("op16",     6'd16, 6'd33, 6'd0,  16'hC0DE, 16'h0000, 16'h0000, 0);
      run_instr("op17",     6'd17, 6'd33, 6'd0,  16'hC0DE, 16'h0000, 16'h0000, 0);
      run_instr("mov",      6'd0,  6'd63, 6'd0,  16'hFFFF, 16'h0000, 16'h0000, 0);
      run_instr("mul_same", 6'd7,  6'd4,  6'd4,  16'h1111, 16'h2222, 16'h0000, 0);
      run_instr("div_fast", 6'd8,  6'd12, 6'd0,  16'h0000, 16'h0000, 16'hFACE, 1);

      // Reset while the MUL high half is being written.
      bus.in_valid = 1'b1;
      bus.opcode   = 6'd7;
      bus.rdst1    = 6'd10;
      bus.rdst2    = 6'd11;
      bus.mul_hi   = 16'h9999;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("rst_hi c1 wr_en", 32'(bus.wr_en), 32'd1);
      @(negedge clk);
      chk("rst_hi c2 wr_en", 32'(bus.wr_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_hi async wr_en",   32'(bus.wr_en),   32'd0);
      chk("rst_hi async retire",  32'(bus.retire),  32'd0);
      chk("rst_hi async wr_data", 32'(bus.wr_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_quiet("rst_hi release");
      @(negedge clk);
      check_quiet("rst_hi release+1");

      // Reset while waiting on the divider; a late div_done must not revive it.
      bus.in_valid = 1'b1;
      bus.opcode   = 6'd8;
      bus.rdst1    = 6'd20;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("rst_div waiting ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_div async ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.div_done = 1'b1;
      bus.div_q    = 16'h4321;
      @(negedge clk);
      bus.div_done = 1'b0;
      check_quiet("rst_div late done");
      @(negedge clk);
      check_quiet("rst_div late done+1");

      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 19));
         op  = (sel < 17) ? 6'(sel) : 6'($urandom_range(17, 63));
         run_instr($sformatf("rnd%0d op%0d", n, op), op, 6'($urandom), 6'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(1, 12)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 in_valid  in  1  upstream ALU stage presents a completed instruction.
REQ-004 in_ready  out  1  block can accept; high only in IDLE.
REQ-005 opcode  in  6  instruction opcode (code[31:26]).
REQ-006 rdst1  in  6  primary destination register address.
REQ-007 rdst2  in  6  secondary destination (MUL high half).
REQ-008 alu_res  in  272  17 packed 16-bit lanes; lane k = result for opcode k (lane 7 = MUL low half).
REQ-009 mul_hi  in  16  MUL result bits [31:16].
REQ-010 div_done  in  1  divider quotient valid pulse.
REQ-011 div_q  in  16  divider quotient, valid with div_done.
REQ-012 wr_en  out  1  register-file write strobe.
REQ-013 wr_addr  out  6  register-file write address.
REQ-014 wr_data  out  16  register-file write data.
REQ-015 retire  out  1  one-cycle pulse when the instruction completes.
REQ-016 illegal  out  1  one-cycle pulse for opcode > 6'b010000.

Function
REQ-017 FSM states: IDLE, WAIT_DIV, WR_LO, WR_HI.
REQ-018 Accept on in_valid & in_ready; capture opcode, rdst1, rdst2, selected lane, mul_hi in that cycle.
REQ-019 From IDLE on accept: STORE (000011) -> IDLE, retire next cycle, no write; DIV (001000) -> WAIT_DIV; opcode > 010000 -> IDLE, illegal next cycle, no write, no retire; all others -> WR_LO.
REQ-020 WR_LO: wr_en=1, wr_addr=rdst1, wr_data=captured lane (or captured div_q); MUL -> WR_HI, else -> IDLE with retire.
REQ-021 WR_HI: wr_en=1, wr_addr=rdst2, wr_data=captured mul_hi; -> IDLE with retire asserted this cycle.
REQ-022 Single-write latency: wr_en one cycle after accept; MUL writes in consecutive cycles 1 and 2 after accept.
REQ-023 WAIT_DIV: hold until div_done; capture div_q, -> WR_LO; no timeout.
REQ-024 div_done outside WAIT_DIV, including the accept cycle, is ignored.
REQ-025 MUL with rdst1 == rdst2: both writes issue; mul_hi value remains.
REQ-026 Outputs registered; wr_en, retire, illegal never high in the same cycle as in_ready acceptance of the next instruction except retire/in_ready overlap is permitted in IDLE-return cycle only.
REQ-027 Input lanes are not resampled after accept; changes on alu_res mid-operation have no effect.

Reset
REQ-028 rst_n low: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, retire=0, illegal=0, captured regs=0, immediately (asynchronously).
REQ-029 Reset during WAIT_DIV, WR_LO or WR_HI abandons the instruction; no further write or retire for it.
REQ-030 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package alu_pkg: 6-bit opcode constants (MOV..LRSH), LANE_W=16, NUM_LANES=17, FSM state enum.
REQ-032 One combinational sub-module wb_lane_sel: selects 16-bit lane from alu_res by opcode.

Verification
REQ-033 ADD opcode 000100, lane4=16'h1234, rdst1=5 -> cycle+1 wr_en, addr 5, data 16'h1234, retire.
REQ-034 MUL 000111, lane7=16'hBEEF, mul_hi=16'h00CA, rdst1=2, rdst2=3 -> addr 2/16'hBEEF then addr 3/16'h00CA, retire on second.
REQ-035 DIV 001000, div_done after 10 cycles with div_q=16'h0007, rdst1=9 -> next cycle write addr 9/16'h0007; in_ready low throughout.
REQ-036 STORE 000011 -> no wr_en, retire cycle+1; opcode 6'b100000 -> illegal pulse, no wr_en, no retire.
REQ-037 rst_n pulsed low in WR_HI of a MUL -> wr_en drops immediately, no retire, in_ready high after release.
